spi_frame_slave: RTL

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_frame_slave.sv | 118 +++++++++++
 1 files changed

// File: rtl/spi_frame_slave.sv
// SPI frame slave: receives DATA_W-bit words on MOSI while CS_n is low and
// transmits IDLE_PATTERN followed by words taken from i_TX_Word on MISO.
module spi_frame_slave #(
    parameter int unsigned          DATA_W       = 8,
    parameter int unsigned          LSB_FIRST    = 0,
    parameter int unsigned          MAX_WORDS    = 256,
    parameter logic [DATA_W-1:0]    IDLE_PATTERN = DATA_W'(8'hA5),
    localparam int unsigned         CNT_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic              w_SPI_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic [DATA_W-1:0] o_RX_Word,
    output logic              o_RX_Valid,
    output logic              o_RX_Toggle,
    output logic              o_TX_Toggle,
    input  logic [DATA_W-1:0] i_TX_Word,
    output logic [CNT_W-1:0]  o_Word_Count,
    output logic              o_Frame_Ovf
);

    localparam int unsigned        BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_WORDS);

    logic [DATA_W-1:0] rx_shift;
    logic [BIT_W-1:0]  rx_bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [BIT_W-1:0]  tx_bit_cnt;
    logic [DATA_W-1:0] tx_hold;

    logic [DATA_W-1:0] rx_next_c;
    logic              word_done_c;
    logic              tx_bit_c;

    // Assembled word including the bit being captured on this edge
    always_comb begin
        rx_next_c = '0;
        if (LSB_FIRST != 0) begin
            rx_next_c = {i_SPI_MOSI, rx_shift[DATA_W-1:1]};
        end else begin
            rx_next_c = {rx_shift[DATA_W-2:0], i_SPI_MOSI};
        end
    end

    // rx_bit_cnt is held at 0 while CS_n is high, so this never fires outside a frame
    assign word_done_c = (rx_bit_cnt == LAST_BIT);

    // Per-frame receive state, cleared whenever the frame ends
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            rx_shift     <= '0;
            rx_bit_cnt   <= '0;
            o_RX_Valid   <= 1'b0;
            o_Word_Count <= '0;
            o_Frame_Ovf  <= 1'b0;
        end else if (i_SPI_CS_n) begin
            rx_shift     <= '0;
            rx_bit_cnt   <= '0;
            o_RX_Valid   <= 1'b0;
            o_Word_Count <= '0;
            o_Frame_Ovf  <= 1'b0;
        end else begin
            rx_shift   <= rx_next_c;
            rx_bit_cnt <= word_done_c ? '0 : rx_bit_cnt + BIT_W'(1);
            o_RX_Valid <= word_done_c;
            if (word_done_c) begin
                if (o_Word_Count < CNT_MAX) begin
                    o_Word_Count <= o_Word_Count + CNT_W'(1);
                end else begin
                    o_Frame_Ovf <= 1'b1;
                end
            end
        end
    end

    // Consumer-facing word and handshake toggles survive the end of a frame
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_Word   <= '0;
            o_RX_Toggle <= 1'b0;
            o_TX_Toggle <= 1'b0;
            tx_hold     <= '0;
        end else if (word_done_c) begin
            o_RX_Word   <= rx_next_c;
            o_RX_Toggle <= ~o_RX_Toggle;
            o_TX_Toggle <= ~o_TX_Toggle;
            tx_hold     <= i_TX_Word;
        end
    end

    // Transmit shifter launches on the falling edge; idles at IDLE_PATTERN
    always_ff @(negedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            tx_shift   <= IDLE_PATTERN;
            tx_bit_cnt <= '0;
        end else if (i_SPI_CS_n) begin
            tx_shift   <= IDLE_PATTERN;
            tx_bit_cnt <= '0;
        end else if (tx_bit_cnt == LAST_BIT) begin
            tx_shift   <= tx_hold;
            tx_bit_cnt <= '0;
        end else begin
            tx_bit_cnt <= tx_bit_cnt + BIT_W'(1);
            if (LSB_FIRST != 0) begin
                tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
            end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign tx_bit_c   = (LSB_FIRST != 0) ? tx_shift[0] : tx_shift[DATA_W-1];
    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : tx_bit_c;

endmodule
